// File: rtl/comp_pkg.sv
// comp_pkg: shared definitions for the iterative magnitude comparator.
//   state_t      - scan FSM states (IDLE, SCAN, DONE)
//   RES_*        - one-hot result encoding {a_less_b, a_greater_b, equal}
//   COMP_WIDTH   - default operand width
//   COMP_DIGIT   - default bits compared per scan cycle
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_LT   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_EQ   = 3'b001;

  localparam int COMP_WIDTH = 16;
  localparam int COMP_DIGIT = 4;

endpackage

// File: rtl/comp_nibble.sv
// comp_nibble: combinational unsigned comparator for one DIGIT-bit digit.
// Ports:
//   i_a, i_b     in  DIGIT  digits of operand A and B
//   a_less_b     out 1      i_a <  i_b
//   a_greater_b  out 1      i_a >  i_b
//   equal        out 1      i_a == i_b
module comp_nibble
  import comp_pkg::*;
#(
  parameter int DIGIT = COMP_DIGIT
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  output logic             a_less_b,
  output logic             a_greater_b,
  output logic             equal
);

  always_comb begin
    a_less_b    = (i_a < i_b);
    a_greater_b = (i_a > i_b);
    equal       = (i_a == i_b);
  end

endmodule

// File: rtl/comp_seq_16.sv
// comp_seq_16: iterative magnitude comparator. Scans the captured operands
// one DIGIT-bit digit per cycle from the most significant digit and stops at
// the first differing digit; result is one-hot {a_less_b, a_greater_b, equal}.
// Optional feature macro: COMP_SIGNED_EN (two's-complement operands).
// Ports:
//   clk          in  1      clock, rising edge
//   rst          in  1      asynchronous active-high reset
//   in_valid     in  1      operand pair presented
//   in_ready     out 1      pair can be accepted (IDLE)
//   in1, in2     in  WIDTH  operands A and B
//   out_valid    out 1      result held (DONE)
//   out_ready    in  1      consumer accepts result
//   a_less_b     out 1      A <  B
//   a_greater_b  out 1      A >  B
//   equal        out 1      A == B
module comp_seq_16
  import comp_pkg::*;
#(
  parameter int WIDTH = COMP_WIDTH,
  parameter int DIGIT = COMP_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_less_b,
  output logic             a_greater_b,
  output logic             equal
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NDIG - 1);

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [IDXW-1:0]   r_idx;
  logic [2:0]        r_res;

  logic [WIDTH-1:0]  w_cap_a;
  logic [WIDTH-1:0]  w_cap_b;
  logic [DIGIT-1:0]  w_dig_a;
  logic [DIGIT-1:0]  w_dig_b;
  logic              w_lt;
  logic              w_gt;
  logic              w_eq;

`ifdef COMP_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign w_cap_a = {~in1[WIDTH-1], in1[WIDTH-2:0]};
  assign w_cap_b = {~in2[WIDTH-1], in2[WIDTH-2:0]};
`else
  assign w_cap_a = in1;
  assign w_cap_b = in2;
`endif

  assign w_dig_a = r_a[r_idx*DIGIT +: DIGIT];
  assign w_dig_b = r_b[r_idx*DIGIT +: DIGIT];

  comp_nibble #(
    .DIGIT(DIGIT)
  ) u_nibble (
    .i_a        (w_dig_a),
    .i_b        (w_dig_b),
    .a_less_b   (w_lt),
    .a_greater_b(w_gt),
    .equal      (w_eq)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid) w_next = SCAN;
      SCAN: if (!w_eq || (r_idx == '0)) w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Flags are cleared on the output handshake so they read zero in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_res <= RES_NONE;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a   <= w_cap_a;
            r_b   <= w_cap_b;
            r_idx <= IDX_TOP;
            r_res <= RES_NONE;
          end
        end
        SCAN: begin
          if (w_lt) begin
            r_res <= RES_LT;
          end else if (w_gt) begin
            r_res <= RES_GT;
          end else if (r_idx == '0) begin
            r_res <= RES_EQ;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_res <= RES_NONE;
        end
        default: r_res <= RES_NONE;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign a_less_b    = r_res[2];
  assign a_greater_b = r_res[1];
  assign equal       = r_res[0];

endmodule

// File: tb/tb_comp_seq_16.sv
module tb_comp_seq_16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        out_valid;
  logic        out_ready;
  logic        a_less_b;
  logic        a_greater_b;
  logic        equal;

  int tests;
  int fails;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] GT = 3'b010;
  localparam logic [2:0] EQ = 3'b001;

  comp_seq_16 #(
    .WIDTH(16),
    .DIGIT(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in1        (in1),
    .in2        (in2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .a_less_b   (a_less_b),
    .a_greater_b(a_greater_b),
    .equal      (equal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2:0] flags();
    return {a_less_b, a_greater_b, equal};
  endfunction

  // Presents one pair, then waits (bounded) for out_valid. edges = number of
  // edges after the accept edge until out_valid, -1 on timeout. viol counts
  // SCAN cycles where in_ready or any flag was high.
  task automatic start_and_wait(input logic [15:0] a, input logic [15:0] b,
                                output int edges, output int viol);
    viol = 0;
    @(negedge clk);
    in1 = a; in2 = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges = 0;
    while (!out_valid && edges < 20) begin
      if (in_ready !== 1'b0 || flags() !== 3'b000) viol++;
      @(posedge clk); #1;
      edges++;
    end
    if (!out_valid) edges = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in1 = '0; in2 = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, out_valid, flags()} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_outputs: got %b want 10000", {in_ready, out_valid, flags()});
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid, flags()} !== 5'b10000) begin
      fails++;
      $display("FAIL idle_after_reset: got %b want 10000", {in_ready, out_valid, flags()});
    end
  endtask

  task automatic test_less();
    int e, v;
    out_ready = 1'b0;
    start_and_wait(16'h003D, 16'h003E, e, v);
    tests++;
    if (e !== 4) begin fails++; $display("FAIL less_latency: got %0d want 4", e); end
    tests++;
    if (v !== 0) begin fails++; $display("FAIL less_scan_quiet: got %0d want 0", v); end
    tests++;
    if (flags() !== LT) begin fails++; $display("FAIL less_flags: got %b want %b", flags(), LT); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid, flags()} !== 5'b10000) begin
      fails++;
      $display("FAIL less_handshake: got %b want 10000", {in_ready, out_valid, flags()});
    end
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_equal();
    int e, v;
    out_ready = 1'b1;
    start_and_wait(16'hBEEF, 16'hBEEF, e, v);
    tests++;
    if (e !== 4) begin fails++; $display("FAIL equal_latency: got %0d want 4", e); end
    tests++;
    if (flags() !== EQ || v !== 0) begin
      fails++; $display("FAIL equal_flags: got %b viol %0d want %b viol 0", flags(), v, EQ);
    end
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++; $display("FAIL equal_one_cycle_valid: got %b want 10", {in_ready, out_valid});
    end
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_msb();
    int e, v;
    logic [2:0] want;
`ifdef COMP_SIGNED_EN
    want = LT;
`else
    want = GT;
`endif
    out_ready = 1'b1;
    start_and_wait(16'h8000, 16'h7FFF, e, v);
    tests++;
    if (e !== 1) begin fails++; $display("FAIL msb_latency: got %0d want 1", e); end
    tests++;
    if (flags() !== want) begin fails++; $display("FAIL msb_flags: got %b want %b", flags(), want); end
    @(posedge clk); #1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int e, v, bad;
    out_ready = 1'b0;
    bad = 0;
    start_and_wait(16'h1200, 16'h1300, e, v);
    tests++;
    if (e !== 2 || flags() !== LT) begin
      fails++; $display("FAIL bp_result: got lat %0d flags %b want lat 2 flags %b", e, flags(), LT);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 1) begin in_valid = 1'b1; in1 = 16'h0001; in2 = 16'h0000; end
      if (i == 3) in_valid = 1'b0;
      @(posedge clk); #1;
      if (flags() !== LT || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); out_ready = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({in_ready, out_valid, flags()} !== 5'b10000) begin
      fails++;
      $display("FAIL bp_pulse_ignored: got %b want 10000", {in_ready, out_valid, flags()});
    end
  endtask

  task automatic test_reset_mid_scan();
    int e, v;
    out_ready = 1'b0;
    @(negedge clk);
    in1 = 16'h1234; in2 = 16'h1235; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    tests++;
    if ({in_ready, out_valid, flags()} !== 5'b10000) begin
      fails++;
      $display("FAIL midscan_reset: got %b want 10000", {in_ready, out_valid, flags()});
    end
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b1;
    start_and_wait(16'h0010, 16'h0001, e, v);
    tests++;
    if (e !== 3 || flags() !== GT) begin
      fails++; $display("FAIL after_reset_cmp: got lat %0d flags %b want lat 3 flags %b", e, flags(), GT);
    end
    @(posedge clk); #1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [2:0]  vf [3];
    int          vk [3];
    int e, v;
    va[0] = 16'h0005; vb[0] = 16'h0005; vf[0] = EQ; vk[0] = 4;
    va[1] = 16'hF000; vb[1] = 16'h0FFF; vf[1] = GT; vk[1] = 1;
    va[2] = 16'h1111; vb[2] = 16'h1112; vf[2] = LT; vk[2] = 4;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_and_wait(va[i], vb[i], e, v);
      tests++;
      if (e !== vk[i] || flags() !== vf[i] || v !== 0) begin
        fails++;
        $display("FAIL b2b_%0d: got lat %0d flags %b viol %0d want lat %0d flags %b viol 0",
                 i, e, flags(), v, vk[i], vf[i]);
      end
      @(posedge clk); #1;
      tests++;
      if ({in_ready, out_valid, flags()} !== 5'b10000) begin
        fails++;
        $display("FAIL b2b_release_%0d: got %b want 10000", i, {in_ready, out_valid, flags()});
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_less();
    test_equal();
    test_msb();
    test_backpressure();
    test_reset_mid_scan();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
